// File: rtl/gray_window_gen_if.sv
// rtl/gray_window_gen_if.sv - pixel stream, line-buffer and window bus of gray_window_gen
`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

interface gray_window_gen_if #(
  parameter int DW = `CNN_DATA_IN_W,
  parameter int AW = `CNN_GRAY_BUFFER_ADDR_W
);
  logic            pix_valid;
  logic [DW-1:0]   pix_in;
  logic [1:0]      lb_wen;
  logic [AW-1:0]   lb_waddr;
  logic [DW-1:0]   lb0_din;
  logic [DW-1:0]   lb1_din;
  logic            lb_ren;
  logic [AW-1:0]   lb_raddr;
  logic [DW-1:0]   lb0_rdata;
  logic [DW-1:0]   lb1_rdata;
  logic [9*DW-1:0] win_out;
  logic            win_valid;
  logic            frame_done;

  modport master (
    output pix_valid, pix_in, lb0_rdata, lb1_rdata,
    input  lb_wen, lb_waddr, lb0_din, lb1_din, lb_ren, lb_raddr,
    input  win_out, win_valid, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, lb0_rdata, lb1_rdata,
    output lb_wen, lb_waddr, lb0_din, lb1_din, lb_ren, lb_raddr,
    output win_out, win_valid, frame_done
  );
endinterface

// File: rtl/gray_window_gen.sv
// rtl/gray_window_gen.sv - line-buffer controller and 3x3 window former for the gray input path
`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

module gray_window_gen #(
  parameter int IMG_IN_WIDTH  = 28,
  parameter int IMG_IN_HEIGHT = 28
) (
  input  logic            clk,
  input  logic            rst,
  gray_window_gen_if.slave bus
);
  localparam int DW = `CNN_DATA_IN_W;
  localparam int AW = `CNN_GRAY_BUFFER_ADDR_W;
  localparam int RW = (IMG_IN_HEIGHT > 4) ? $clog2(IMG_IN_HEIGHT) : 2;
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_IN_HEIGHT - 1);

  logic [AW-1:0]   col;
  logic [RW-1:0]   row;
  logic [AW-1:0]   col_d;
  logic [RW-1:0]   row_d;
  logic [DW-1:0]   pix_d;
  logic            v1;
  logic            last_d;
  logic [DW-1:0]   win [3][3];
  logic [9*DW-1:0] win_flat;
  logic            win_valid_q;
  logic            frame_done_q;
  logic            accept;
  logic            wr;
  logic            at_col_last;
  logic            at_row_last;

  assign accept      = bus.pix_valid & ~rst;
  assign wr          = v1 & ~rst;
  assign at_col_last = (col == COL_LAST);
  assign at_row_last = (row == ROW_LAST);

  // Read is issued in the pixel's own cycle; the write to the same address follows
  // one cycle later, once both buffers have returned their old contents.
  assign bus.lb_ren   = accept;
  assign bus.lb_raddr = accept ? col : '0;
  assign bus.lb_wen   = {2{wr}};
  assign bus.lb_waddr = wr ? col_d : '0;
  assign bus.lb0_din  = wr ? pix_d : '0;
  assign bus.lb1_din  = wr ? bus.lb0_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      col_d        <= '0;
      row_d        <= '0;
      pix_d        <= '0;
      v1           <= 1'b0;
      last_d       <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      if (bus.pix_valid) begin
        col    <= at_col_last ? '0 : col + 1'b1;
        if (at_col_last) begin
          row <= at_row_last ? '0 : row + 1'b1;
        end
        pix_d  <= bus.pix_in;
        col_d  <= col;
        row_d  <= row;
        last_d <= at_row_last & at_col_last;
      end
      v1           <= bus.pix_valid;
      win_valid_q  <= v1 && (row_d >= RW'(2)) && (col_d >= AW'(2));
      frame_done_q <= v1 & last_d;
      // Newest column enters at j=2: top from LB1 (r-2), middle from LB0 (r-1), bottom is live.
      if (v1) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= bus.lb1_rdata;
        win[1][2] <= bus.lb0_rdata;
        win[2][2] <= pix_d;
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat[(3*i+j)*DW +: DW] = win[i][j];
      end
    end
  end

  assign bus.win_out    = win_flat;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_window_gen.sv
// tb/tb_gray_window_gen.sv - self-checking bench for gray_window_gen
`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

module tb_gray_window_gen;
  localparam int DW = `CNN_DATA_IN_W;
  localparam int AW = `CNN_GRAY_BUFFER_ADDR_W;
  localparam int SW = 5;
  localparam int SH = 4;
  localparam int BW = 28;
  localparam int BH = 28;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  always #5 clk = ~clk;

  gray_window_gen_if s_if ();
  gray_window_gen_if b_if ();

  gray_window_gen #(.IMG_IN_WIDTH(SW), .IMG_IN_HEIGHT(SH)) dut_s (
    .clk(clk), .rst(rst_s), .bus(s_if.slave)
  );
  gray_window_gen #(.IMG_IN_WIDTH(BW), .IMG_IN_HEIGHT(BH)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave)
  );

  // Behavioural graylinebuffer pairs: synchronous read and write, no reset.
  logic [DW-1:0] s_mem0 [32];
  logic [DW-1:0] s_mem1 [32];
  logic [DW-1:0] b_mem0 [32];
  logic [DW-1:0] b_mem1 [32];

  always @(posedge clk) begin
    if (s_if.lb_ren) begin
      s_if.lb0_rdata <= s_mem0[s_if.lb_raddr];
      s_if.lb1_rdata <= s_mem1[s_if.lb_raddr];
    end
    if (s_if.lb_wen[0]) s_mem0[s_if.lb_waddr] <= s_if.lb0_din;
    if (s_if.lb_wen[1]) s_mem1[s_if.lb_waddr] <= s_if.lb1_din;
    if (b_if.lb_ren) begin
      b_if.lb0_rdata <= b_mem0[b_if.lb_raddr];
      b_if.lb1_rdata <= b_mem1[b_if.lb_raddr];
    end
    if (b_if.lb_wen[0]) b_mem0[b_if.lb_waddr] <= b_if.lb0_din;
    if (b_if.lb_wen[1]) b_mem1[b_if.lb_waddr] <= b_if.lb1_din;
  end

  int checks = 0;
  int errors = 0;

  logic [9*DW-1:0] win_q [$];
  bit              fd_q  [$];
  int              tag_q [$];
  int              fd_stray;
  int              h1;
  int              h2;

  logic [DW-1:0] img [BH][BW];

  function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[(3*i+j)*DW +: DW] = DW'(base + 10*(r-2+i) + (c-2+j));
      end
    end
    return w;
  endfunction

  // One small-DUT cycle: record what the window port shows, then drive the next inputs.
  task automatic step_s(input bit v, input int d, input bit r);
    @(negedge clk);
    if (s_if.win_valid) begin
      win_q.push_back(s_if.win_out);
      fd_q.push_back(s_if.frame_done);
      tag_q.push_back(h2);
    end else if (s_if.frame_done) begin
      fd_stray++;
    end
    h2 = h1;
    h1 = (v && !r) ? d : -1;
    s_if.pix_valid = v;
    s_if.pix_in    = d[DW-1:0];
    rst_s          = r;
  endtask

  task automatic clear_rec();
    win_q.delete();
    fd_q.delete();
    tag_q.delete();
    fd_stray = 0;
    h1 = -1;
    h2 = -1;
  endtask

  task automatic reset_s();
    step_s(0, 0, 1);
    step_s(0, 0, 1);
    clear_rec();
  endtask

  task automatic drive_small(input int base, input int max_gap, input int stop_r, input int stop_c);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) step_s(0, int'($urandom), 0);
        if (r == stop_r && c == stop_c) begin
          step_s(1, base + 10*r + c, 1);
          return;
        end
        step_s(1, base + 10*r + c, 0);
      end
    end
  endtask

  task automatic flush_s(input int n);
    repeat (n) step_s(0, int'($urandom), 0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step_s(k[0] ? 1'b0 : 1'b1, int'($urandom), 1);
      #1;
      if (k > 0) begin
        checks++; if (s_if.lb_ren !== 1'b0) begin errors++; $display("FAIL rst_lb_ren got %b exp 0", s_if.lb_ren); end
        checks++; if (s_if.lb_raddr !== '0) begin errors++; $display("FAIL rst_lb_raddr got %0d exp 0", s_if.lb_raddr); end
        checks++; if (s_if.lb_wen !== 2'b00) begin errors++; $display("FAIL rst_lb_wen got %b exp 00", s_if.lb_wen); end
        checks++; if (s_if.lb_waddr !== '0) begin errors++; $display("FAIL rst_lb_waddr got %0d exp 0", s_if.lb_waddr); end
        checks++; if (s_if.lb0_din !== '0) begin errors++; $display("FAIL rst_lb0_din got %0d exp 0", s_if.lb0_din); end
        checks++; if (s_if.lb1_din !== '0) begin errors++; $display("FAIL rst_lb1_din got %0d exp 0", s_if.lb1_din); end
        checks++; if (s_if.win_valid !== 1'b0) begin errors++; $display("FAIL rst_win_valid got %b exp 0", s_if.win_valid); end
        checks++; if (s_if.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", s_if.frame_done); end
        checks++; if (s_if.win_out !== '0) begin errors++; $display("FAIL rst_win_out got %h exp 0", s_if.win_out); end
      end
    end
  endtask

  task automatic test_small_frame();
    reset_s();
    drive_small(0, 0, -1, -1);
    flush_s(3);
    checks++; if (win_q.size() != 6) begin errors++; $display("FAIL small_count got %0d exp 6", win_q.size()); end
    checks++; if (fd_stray != 0) begin errors++; $display("FAIL small_fd_stray got %0d exp 0", fd_stray); end
    for (int k = 0; k < 6 && k < win_q.size(); k++) begin
      int r, c;
      r = 2 + k/3;
      c = 2 + k%3;
      checks++; if (win_q[k] !== exp_win(0, r, c)) begin errors++; $display("FAIL small_win%0d got %h exp %h", k, win_q[k], exp_win(0, r, c)); end
      checks++; if (tag_q[k] != 10*r + c) begin errors++; $display("FAIL small_lat%0d got %0d exp %0d", k, tag_q[k], 10*r + c); end
      checks++; if (fd_q[k] !== (k == 5)) begin errors++; $display("FAIL small_fd%0d got %b exp %b", k, fd_q[k], k == 5); end
    end
  endtask

  task automatic test_gaps();
    reset_s();
    drive_small(0, 3, -1, -1);
    flush_s(3);
    checks++; if (win_q.size() != 6) begin errors++; $display("FAIL gap_count got %0d exp 6", win_q.size()); end
    checks++; if (fd_stray != 0) begin errors++; $display("FAIL gap_fd_stray got %0d exp 0", fd_stray); end
    for (int k = 0; k < 6 && k < win_q.size(); k++) begin
      int r, c;
      r = 2 + k/3;
      c = 2 + k%3;
      checks++; if (win_q[k] !== exp_win(0, r, c)) begin errors++; $display("FAIL gap_win%0d got %h exp %h", k, win_q[k], exp_win(0, r, c)); end
      checks++; if (tag_q[k] != 10*r + c) begin errors++; $display("FAIL gap_lat%0d got %0d exp %0d", k, tag_q[k], 10*r + c); end
      checks++; if (fd_q[k] !== (k == 5)) begin errors++; $display("FAIL gap_fd%0d got %b exp %b", k, fd_q[k], k == 5); end
    end
  endtask

  task automatic test_back_to_back();
    reset_s();
    drive_small(0, 0, -1, -1);
    drive_small(100, 0, -1, -1);
    flush_s(3);
    checks++; if (win_q.size() != 12) begin errors++; $display("FAIL b2b_count got %0d exp 12", win_q.size()); end
    for (int k = 0; k < 12 && k < win_q.size(); k++) begin
      int r, c, b;
      b = (k < 6) ? 0 : 100;
      r = 2 + (k%6)/3;
      c = 2 + (k%6)%3;
      checks++; if (win_q[k] !== exp_win(b, r, c)) begin errors++; $display("FAIL b2b_win%0d got %h exp %h", k, win_q[k], exp_win(b, r, c)); end
      checks++; if (fd_q[k] !== (k == 5 || k == 11)) begin errors++; $display("FAIL b2b_fd%0d got %b exp %b", k, fd_q[k], k == 5 || k == 11); end
    end
  endtask

  task automatic test_reset_mid();
    reset_s();
    drive_small(0, 0, 2, 3);
    drive_small(50, 0, -1, -1);
    flush_s(3);
    checks++; if (win_q.size() != 6) begin errors++; $display("FAIL rmid_count got %0d exp 6", win_q.size()); end
    checks++; if (fd_stray != 0) begin errors++; $display("FAIL rmid_fd_stray got %0d exp 0", fd_stray); end
    for (int k = 0; k < 6 && k < win_q.size(); k++) begin
      int r, c;
      r = 2 + k/3;
      c = 2 + k%3;
      checks++; if (win_q[k] !== exp_win(50, r, c)) begin errors++; $display("FAIL rmid_win%0d got %h exp %h", k, win_q[k], exp_win(50, r, c)); end
      checks++; if (tag_q[k] != 50 + 10*r + c) begin errors++; $display("FAIL rmid_lat%0d got %0d exp %0d", k, tag_q[k], 50 + 10*r + c); end
    end
  endtask

  task automatic test_addr();
    int nwin, nfd, pr, pc, r, c;
    b_if.pix_valid = 1'b0;
    b_if.pix_in    = '0;
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    nwin = 0; nfd = 0; pr = -1; pc = -1; r = 0; c = 0;
    for (int n = 0; n < BW*BH + 3; n++) begin
      @(negedge clk);
      if (b_if.win_valid) nwin++;
      if (b_if.frame_done) nfd++;
      if (n < BW*BH) begin
        r = n / BW;
        c = n % BW;
        img[r][c] = DW'($urandom);
        b_if.pix_valid = 1'b1;
        b_if.pix_in    = img[r][c];
      end else begin
        b_if.pix_valid = 1'b0;
      end
      #1;
      if (n < BW*BH) begin
        checks++; if (b_if.lb_ren !== 1'b1 || b_if.lb_raddr !== AW'(c)) begin errors++; $display("FAIL addr_rd r%0d c%0d got ren=%b raddr=%0d exp ren=1 raddr=%0d", r, c, b_if.lb_ren, b_if.lb_raddr, c); end
      end else begin
        checks++; if (b_if.lb_ren !== 1'b0) begin errors++; $display("FAIL addr_idle_ren got %b exp 0", b_if.lb_ren); end
      end
      if (pr >= 0) begin
        checks++; if (b_if.lb_wen !== 2'b11 || b_if.lb_waddr !== AW'(pc)) begin errors++; $display("FAIL addr_wr r%0d c%0d got wen=%b waddr=%0d exp wen=11 waddr=%0d", pr, pc, b_if.lb_wen, b_if.lb_waddr, pc); end
        checks++; if (b_if.lb0_din !== img[pr][pc]) begin errors++; $display("FAIL addr_lb0_din r%0d c%0d got %0d exp %0d", pr, pc, b_if.lb0_din, img[pr][pc]); end
        if (pr >= 1) begin
          checks++; if (b_if.lb1_din !== img[pr-1][pc]) begin errors++; $display("FAIL addr_lb1_din r%0d c%0d got %0d exp %0d", pr, pc, b_if.lb1_din, img[pr-1][pc]); end
        end
      end else if (n > 0) begin
        checks++; if (b_if.lb_wen !== 2'b00) begin errors++; $display("FAIL addr_idle_wen got %b exp 00", b_if.lb_wen); end
      end
      if (n < BW*BH) begin pr = r; pc = c; end else begin pr = -1; pc = -1; end
    end
    checks++; if (nwin != (BW-2)*(BH-2)) begin errors++; $display("FAIL big_win_count got %0d exp %0d", nwin, (BW-2)*(BH-2)); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL big_fd_count got %0d exp 1", nfd); end
  endtask

  initial begin
    s_if.pix_valid = 1'b0;
    s_if.pix_in    = '0;
    b_if.pix_valid = 1'b0;
    b_if.pix_in    = '0;
    rst_s = 1'b1;
    rst_b = 1'b1;
    clear_rec();
    test_reset();
    test_small_frame();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
